// File: rtl/sat_add_pipe_if.sv
// rtl/sat_add_pipe_if.sv - valid/ready operand and result bus for sat_add_pipe
interface sat_add_pipe_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   mode;
  logic         clr_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         sat;
  logic [W-1:0] acc;
  logic         sat_sticky;

  modport master (
    output in_valid, op_a, op_b, mode, clr_sticky, out_ready,
    input  in_ready, out_valid, sum, sat, acc, sat_sticky
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, clr_sticky, out_ready,
    output in_ready, out_valid, sum, sat, acc, sat_sticky
  );
endinterface

// File: rtl/sat_add_pipe.sv
// rtl/sat_add_pipe.sv - two-stage unsigned saturating/wrapping adder with accumulator
module sat_add_pipe #(
  parameter int W = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  sat_add_pipe_if.slave bus
);
  logic         r_s1_valid;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;
  logic [1:0]   r_s1_mode;
  logic         r_out_valid;
  logic [W-1:0] r_sum;
  logic         r_sat;
  logic [W-1:0] r_acc;
  logic         r_sticky;

  logic         w_stall;
  logic         w_s2_load;
  logic [W-1:0] w_y;
  logic [W:0]   w_t;
  logic [W-1:0] w_sum;
  logic         w_sat;

  assign w_stall   = r_out_valid && !bus.out_ready;
  assign w_s2_load = !w_stall && r_s1_valid;

  // Accumulate mode takes acc as the second operand; acc is already updated by
  // the previous transaction, so back-to-back accumulates need no bypass.
  assign w_y = (r_s1_mode == 2'd2) ? r_acc : r_s1_b;
  assign w_t = {1'b0, r_s1_a} + {1'b0, w_y};

  always_comb begin
    w_sum = w_t[W-1:0];
    w_sat = 1'b0;
    case (r_s1_mode)
      2'd0, 2'd2: begin
        if (w_t[W]) begin
          w_sum = '1;
          w_sat = 1'b1;
        end
      end
      2'd3:    w_sum = r_s1_a;
      default: w_sum = w_t[W-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_mode   <= 2'd0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_sat       <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1_valid  <= bus.in_valid;
        r_s1_a      <= bus.op_a;
        r_s1_b      <= bus.op_b;
        r_s1_mode   <= bus.mode;
        r_out_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_sum <= w_sum;
        r_sat <= w_sat;
        if (r_s1_mode[1]) begin
          r_acc <= w_sum;
        end
      end
      // A new saturation outranks a simultaneous clear.
      if (w_s2_load && w_sat) begin
        r_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !w_stall && !i_rst;
  assign bus.out_valid  = r_out_valid;
  assign bus.sum        = r_sum;
  assign bus.sat        = r_sat;
  assign bus.acc        = r_acc;
  assign bus.sat_sticky = r_sticky;
endmodule

// File: tb/tb_sat_add_pipe.sv
// tb/tb_sat_add_pipe.sv - scoreboard bench for sat_add_pipe at W=8 and W=2
module tb_sat_add_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sat_add_pipe_if #(.W(8)) bi8 ();
  sat_add_pipe_if #(.W(2)) bi2 ();

  sat_add_pipe #(.W(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(bi8));
  sat_add_pipe #(.W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bi2));

  typedef struct {
    logic [7:0] sum;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t       q8[$];
  exp_t       q2[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] m_acc = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] m, input logic [7:0] acc_in,
                                output logic [7:0] s, output logic st);
    logic [8:0] t;
    logic [8:0] mx;
    mx = 9'((1 << w) - 1);
    t  = {1'b0, a} + {1'b0, (m == 2'd2) ? acc_in : b};
    s  = 8'h00;
    st = 1'b0;
    case (m)
      2'd0, 2'd2: begin
        if (t > mx) begin
          s  = mx[7:0];
          st = 1'b1;
        end else begin
          s = t[7:0];
        end
      end
      2'd1:    s = t[7:0] & mx[7:0];
      default: s = a;
    endcase
  endfunction

  // One cycle: drive inputs just after the edge, settle, score, advance.
  task automatic step(input logic v8, input logic [7:0] a8, input logic [7:0] bb8,
                      input logic [1:0] m8, input logic ordy, input logic clr,
                      input logic v2, input logic [1:0] a2, input logic [1:0] bb2,
                      output logic took);
    exp_t       e;
    logic [7:0] s;
    logic       st;
    bi8.in_valid   = v8;
    bi8.op_a       = a8;
    bi8.op_b       = bb8;
    bi8.mode       = m8;
    bi8.out_ready  = ordy;
    bi8.clr_sticky = clr;
    bi2.in_valid   = v2;
    bi2.op_a       = a2;
    bi2.op_b       = bb2;
    bi2.mode       = 2'd0;
    bi2.out_ready  = 1'b1;
    bi2.clr_sticky = 1'b0;
    #1;
    check("in_ready8", bi8.in_ready, !(bi8.out_valid && !ordy) && !rst);
    if (bi8.out_valid && ordy) begin
      check("out8_expected", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("sum8", bi8.sum, e.sum);
        check("sat8", bi8.sat, e.sat);
      end
    end
    if (bi2.out_valid) begin
      check("out2_expected", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("sum2", bi2.sum, e.sum);
        check("sat2", bi2.sat, e.sat);
        check("lat2", cyc - e.cyc, 2);
      end
    end
    took = v8 && bi8.in_ready;
    if (took) begin
      model(8, a8, bb8, m8, m_acc, s, st);
      if (m8[1]) m_acc = s;
      e.sum = s;
      e.sat = st;
      e.cyc = cyc;
      q8.push_back(e);
    end
    if (v2 && bi2.in_ready) begin
      model(2, {6'b0, a2}, {6'b0, bb2}, 2'd0, 8'h00, s, st);
      e.sum = s;
      e.sat = st;
      e.cyc = cyc;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic t;
    step(1'b0, 8'h00, 8'h00, 2'd0, ordy, clr, 1'b0, 2'd0, 2'd0, t);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic ordy);
    logic t;
    step(1'b1, a, b, m, ordy, 1'b0, 1'b0, 2'd0, 2'd0, t);
    check("send_accepted", t, 1);
  endtask

  task automatic drain(input logic rnd);
    for (int k = 0; k < 200 && (q8.size() != 0 || q2.size() != 0); k++) begin
      idle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    end
    check("drained8", q8.size(), 0);
    check("drained2", q2.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       t;
    int         sent;
    rst = 1'b1;
    bi8.in_valid = 1'b0; bi8.op_a = '0; bi8.op_b = '0; bi8.mode = 2'd0;
    bi8.out_ready = 1'b1; bi8.clr_sticky = 1'b0;
    bi2.in_valid = 1'b0; bi2.op_a = '0; bi2.op_b = '0; bi2.mode = 2'd0;
    bi2.out_ready = 1'b1; bi2.clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bi8.in_ready, 0);
    check("rst_out_valid", bi8.out_valid, 0);
    check("rst_sum", bi8.sum, 0);
    check("rst_sat", bi8.sat, 0);
    check("rst_acc", bi8.acc, 0);
    check("rst_sticky", bi8.sat_sticky, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bi8.in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 2'(i >> 2), 2'(i), t);
    end
    drain(1'b0);

    send(8'hF0, 8'h20, 2'd0, 1'b1);
    send(8'hF0, 8'h20, 2'd1, 1'b1);
    send(8'h7F, 8'h80, 2'd0, 1'b1);
    drain(1'b0);
    check("sticky_after_sat", bi8.sat_sticky, 1);

    send(8'h10, 8'h00, 2'd3, 1'b1);
    send(8'h40, 8'hAA, 2'd2, 1'b1);
    send(8'h40, 8'h55, 2'd2, 1'b1);
    send(8'h80, 8'h00, 2'd2, 1'b1);
    drain(1'b0);
    check("acc_ff", bi8.acc, 8'hFF);
    send(8'h20, 8'h00, 2'd3, 1'b1);
    send(8'h01, 8'h02, 2'd0, 1'b1);
    send(8'h05, 8'h00, 2'd2, 1'b1);
    drain(1'b0);
    check("acc_interleave", bi8.acc, 8'h25);

    idle(1'b1, 1'b1);
    check("lone_clr", bi8.sat_sticky, 0);
    send(8'hC0, 8'hC0, 2'd0, 1'b1);
    drain(1'b0);
    check("sticky_set", bi8.sat_sticky, 1);
    send(8'hFF, 8'h01, 2'd0, 1'b1);
    idle(1'b1, 1'b1);
    check("set_beats_clr", bi8.sat_sticky, 1);
    idle(1'b1, 1'b1);
    check("clr_after", bi8.sat_sticky, 0);
    drain(1'b0);

    sent = 0;
    for (int k = 0; k < 300 && sent < 8; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'd0, 2'd0, t);
      if (t) sent++;
    end
    check("bp_sent", sent, 8);
    drain(1'b1);
    check("bp_acc", bi8.acc, m_acc);

    send(8'hFF, 8'hFF, 2'd0, 1'b1);
    send(8'h33, 8'h00, 2'd3, 1'b1);
    send(8'h01, 8'h01, 2'd0, 1'b1);
    idle(1'b0, 1'b0);
    check("pre_rst_acc", bi8.acc, 8'h33);
    check("pre_rst_valid", bi8.out_valid, 1);
    check("pre_rst_sticky", bi8.sat_sticky, 1);
    rst = 1'b1;
    idle(1'b0, 1'b0);
    check("mid_rst_valid", bi8.out_valid, 0);
    check("mid_rst_acc", bi8.acc, 0);
    check("mid_rst_sticky", bi8.sat_sticky, 0);
    q8.delete();
    m_acc = 8'h00;
    rst = 1'b0;
    send(8'h12, 8'h34, 2'd0, 1'b1);
    check("post_rst_gap", bi8.out_valid, 0);
    idle(1'b1, 1'b0);
    check("post_rst_valid", bi8.out_valid, 1);
    check("post_rst_sum", bi8.sum, 8'h46);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sat_add_pipe.md
# sat_add_pipe

Parametrised, pipelined, unsigned saturating adder and accumulator with valid/ready handshakes on both sides. Generalises the team's 2-bit saturating adder in four ways:
- Operand width W.
- Wrap or saturate selectable per transaction.
- An internal accumulator with its own modes.
- A sticky saturation flag.

It sits between a valid/ready producer and consumer in the datapath. It clamps results to [0, 2^W-1] unless told to wrap.

## Interface
- W, default 8: operand/result width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block accepts a transaction this cycle.
- op_a  in  W  first unsigned operand.
- op_b  in  W  second unsigned operand; ignored in modes 2 and 3.
- mode  in  2  operation select:
  - 0: saturating a+b
  - 1: wrapping a+b
  - 2: saturating acc+a
  - 3: load acc with a
- clr_sticky  in  1  clears sat_sticky.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- sat  out  1  the result on sum was clamped (mode 0 or 2 only).
- acc  out  W  current accumulator value.
- sat_sticky  out  1  set when any transaction produced sat=1.

## Operation
- Two stages:
  - S1 registers op_a, op_b and mode.
  - S2 computes a W+1-bit sum from the S1 registers (and acc in mode 2), then registers sum/sat.
- Input accept: transfer when in_valid && in_ready.
- Output accept: transfer when out_valid && out_ready.
- stall = out_valid && !out_ready.
- in_ready = !stall && !rst.
- While stall is true, S1 and S2 hold all contents.
- When not stalled:
  - S2 loads from S1 (valid bit included).
  - S1 loads the input transaction, or a bubble if in_valid=0.
- Arithmetic: t = {1'b0,x} + {1'b0,y}, W+1 bits, unsigned.
  - Mode 0 / mode 2: if t[W] then sum = all-ones and sat = 1; else sum = t[W-1:0] and sat = 0.
  - Mode 1: sum = t[W-1:0] and sat = 0, even on carry-out.
  - Mode 3: sum = op_a and sat = 0.
- Accumulator:
  - Updated only on the edge where an S1 transaction with mode 2 or 3 moves into S2.
  - New acc = that transaction's sum.
  - Modes 0 and 1 never change acc.
  - Back-to-back mode-2 transactions each see the acc written by the previous one; there is no hazard and no bubble.
- sat_sticky:
  - Sets on the edge a transaction with sat=1 enters S2.
  - clr_sticky clears it.
  - If both occur on the same edge, the set wins.
- Unsigned only: no negative inputs and no underflow path.

## Timing
- Reset values: out_valid=0, sum=0, sat=0, acc=0, sat_sticky=0; S1 valid=0.
- in_ready=0 while rst is high; it is 1 the first cycle after rst deasserts.
- Latency: a transaction accepted at edge N appears on out_valid/sum after edge N+2, provided there is no stall.
- Throughput: one transaction per cycle while out_ready=1.
- Stall response:
  - out_ready low with out_valid high drops in_ready combinationally in the same cycle.
  - No transaction is lost or duplicated.
  - sum/sat/acc are stable for the whole stall.
- Reset mid-operation: both stages are flushed and acc is cleared on the next edge. In-flight transactions are discarded and no out_valid is issued for them.
- out_ready high while out_valid=0: no effect.
- sum/sat change only on an edge where S2 loads.

## Test plan
- Exhaustive, W=2, mode 0: all 16 op_a/op_b pairs. Expected: 01+01 gives 10, sat=0; 10+01 gives 11, sat=0; 10+10 gives 11, sat=1; 11+11 gives 11, sat=1. Each result arrives exactly 2 cycles after accept.
- Modes 0 vs 1, W=8, operands 0xF0 + 0x20:
  - Mode 0 gives sum=0xFF, sat=1, sat_sticky=1.
  - Mode 1 gives sum=0x10, sat=0.
  - 0x7F+0x80 in mode 0 gives 0xFF, sat=0.
- Accumulate, W=8:
  - Mode 3 with a=0x10, then mode 2 with a=0x40, 0x40, 0x80 back-to-back gives sums 0x10, 0x50, 0x90, 0xFF (the last with sat=1); acc ends at 0xFF.
  - An interleaved mode-0 transaction leaves acc unchanged.
- Backpressure: stream 8 transactions while out_ready toggles pseudo-randomly. Outputs must match the reference model in order, with no drops or duplicates; in_ready must equal !(out_valid && !out_ready).
- Sticky: generate a saturating result, then assert clr_sticky on the same edge as another saturating transaction enters S2; sat_sticky must stay 1. A lone clr_sticky must clear it to 0.
- Reset mid-stream: assert rst with both stages full and acc=0x33. The next cycle must show out_valid=0, acc=0 and sat_sticky=0; the first post-reset transaction must produce a correct result at +2 cycles.
